// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states
// and the legality test used to flag unsupported op codes.
package alu_pkg;

    localparam int OP_W = 4;

    // Low encodings are kept from the previous combinational ALU so that
    // existing decode tables keep working unchanged.
    typedef enum logic [OP_W-1:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_SLT  = 4'd2,
        OP_ADD  = 4'd3,
        OP_SLL  = 4'd4,
        OP_SRL  = 4'd5,
        OP_SUB  = 4'd6,
        OP_XOR  = 4'd7,
        OP_SRA  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DONE     = 2'd2
    } state_e;

    // Codes above MUL are reserved and report illegal.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle between the operand stage, the ALU and writeback.
// The producer/consumer side uses master, the ALU uses slave.
interface seq_alu_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             sign;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, sign, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, sign, illegal
    );

endinterface

// File: rtl/alu_comb.sv
// Combinational datapath for every single-cycle operation plus the illegal
// flag. MUL is legal but its value comes from the iterative multiplier in
// seq_alu, so here it yields zero.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             illegal
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W-1:0] shamt;
    logic               lt_signed;
    logic               lt_unsigned;

    // Only the low bits of b select the shift distance.
    assign shamt       = b[SHAMT_W-1:0];
    assign lt_signed   = ($signed(a) < $signed(b));
    assign lt_unsigned = (a < b);

    // Operation select.
    always_comb begin
        // NOTE: every output gets a default first, so no branch can leave it unassigned and infer a latch.
        res     = '0;
        illegal = !is_legal_op(op);
        case (op)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OP_SLL:  res = a << shamt;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = $signed(a) >>> shamt;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready on both sides. Single-cycle ops complete
// with latency 1; MUL runs a WIDTH-step shift-and-add. The registered
// result is held until the consumer takes it.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    seq_alu_if.slave bus
);

    localparam int SHAMT_W = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             sign;
        logic             illegal;
    } out_t;

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    state_e             state_q;
    state_e             state_d;

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   acc_q;
    logic [SHAMT_W-1:0] cnt_q;
    out_t               out_q;

    logic [WIDTH-1:0]   comb_res;
    logic               comb_illegal;
    logic [WIDTH-1:0]   acc_next;
    logic               mul_last;
    logic               accept;
    logic               accept_mul;

    function automatic out_t pack_out(input logic [WIDTH-1:0] r, input logic ill);
        out_t o;
        o.result  = r;
        o.zero    = (r == '0);
        o.sign    = r[WIDTH-1];
        o.illegal = ill;
        return o;
    endfunction

    alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
        .op      (bus.op),
        .a       (bus.a),
        .b       (bus.b),
        .res     (comb_res),
        .illegal (comb_illegal)
    );

    // Handshake decode and multiplier step.
    assign accept     = bus.in_valid && (state_q == IDLE);
    assign accept_mul = accept && (bus.op == OP_MUL);
    assign acc_next   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mul_last   = (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = (bus.op == OP_MUL) ? MUL_BUSY : DONE;
                end
            end
            MUL_BUSY: begin
                if (mul_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, shift-and-add multiplier and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the multiplier registers are cleared as well as the outputs, so a reset mid-multiply leaves no partial product behind.
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= pack_out('0, 1'b0);
        end else if (accept_mul) begin
            mcand_q  <= bus.a;
            mplier_q <= bus.b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            out_q    <= pack_out(comb_res, comb_illegal);
        end else if (state_q == MUL_BUSY) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + SHAMT_W'(1);
            // The final step's sum goes straight to the output register.
            if (mul_last) begin
                out_q <= pack_out(acc_next, 1'b0);
            end
        end
    end

    assign bus.result  = out_q.result;
    assign bus.zero    = out_q.zero;
    assign bus.sign    = out_q.sign;
    assign bus.illegal = out_q.illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: reset behaviour, directed vectors,
// multi-cycle corner sequences and random ops against a reference model.
module tb_seq_alu;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic       ill;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: straight arithmetic on wide integers.
    function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] r, output logic ill, output int lat);
        int unsigned       sh;
        longint            sa;
        longint unsigned   prod;
        sh   = b % W;
        sa   = longint'($signed(a));
        prod = longint'(a) * longint'(b);
        ill  = 1'b0;
        lat  = 1;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = (int'(a) < int'(b)) ? 1 : 0;
            4'd3:  r = W'(longint'(a) + longint'(b));
            4'd4:  r = W'(longint'(a) * (64'd1 << sh));
            4'd5:  r = W'(longint'(a) / (64'd1 << sh));
            4'd6:  r = W'(longint'(a) - longint'(b));
            4'd7:  r = a ^ b;
            4'd8:  r = W'(sa >>> sh);
            4'd9:  r = (a < b) ? 1 : 0;
            4'd10: begin r = prod[W-1:0]; lat = W + 1; end
            default: begin r = '0; ill = 1'b1; end
        endcase
    endfunction

    // One complete transaction: issue, wait for out_valid, take the result.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit eager, output logic [W-1:0] res, output logic z,
                          output logic s, output logic ill, output int lat);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = eager;
        tick();
        bus.in_valid  = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        res = bus.result;
        z   = bus.zero;
        s   = bus.sign;
        ill = bus.illegal;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_drop", bus.out_valid, 0);
    endtask

    initial begin
        logic [W-1:0] res, exp_r;
        logic z, s, ill, exp_ill;
        int   lat, exp_lat;
        bit   seen;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 4'd0;
        bus.a         = '0;
        bus.b         = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready",  bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result",    bus.result, 0);
        check("rst_zero",      bus.zero, 1);
        check("rst_sign",      bus.sign, 0);
        check("rst_illegal",   bus.illegal, 0);

        // Reset in the middle of a multiply.
        bus.op = 4'd10; bus.a = 32'h1234_5678; bus.b = 32'h9ABC_DEF1; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midmul_in_ready",  bus.in_ready, 1);
        check("midmul_out_valid", bus.out_valid, 0);
        check("midmul_result",    bus.result, 0);
        check("midmul_zero",      bus.zero, 1);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("midmul_no_stale", seen, 0);

        // Directed vectors.
        vecs.push_back('{"add_wrap",  4'd3,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1});
        vecs.push_back('{"sub_neg",   4'd6,  32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1});
        vecs.push_back('{"sll",       4'd4,  32'h8000_0010, 32'h24,        32'h0000_0100, 1'b0, 1});
        vecs.push_back('{"srl",       4'd5,  32'h8000_0010, 32'h24,        32'h0800_0001, 1'b0, 1});
        vecs.push_back('{"sra",       4'd8,  32'h8000_0010, 32'h24,        32'hF800_0001, 1'b0, 1});
        vecs.push_back('{"slt",       4'd2,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1});
        vecs.push_back('{"sltu",      4'd9,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1});
        vecs.push_back('{"illegal13", 4'd13, 32'h5,         32'h5,         32'h0,         1'b1, 1});
        vecs.push_back('{"xor",       4'd7,  32'hF0,        32'hFF,        32'h0F,        1'b0, 1});
        vecs.push_back('{"mul",       4'd10, 32'h0001_2345, 32'h0001_0001, 32'h2346_2345, 1'b0, 33});
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, (i < 2), res, z, s, ill, lat);
            check({vecs[i].name, "_result"},  res, vecs[i].res);
            check({vecs[i].name, "_zero"},    z,   (vecs[i].res == 0));
            check({vecs[i].name, "_sign"},    s,   vecs[i].res[W-1]);
            check({vecs[i].name, "_illegal"}, ill, vecs[i].ill);
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
        end

        // MUL with a held request and operands changing while busy.
        bus.op = 4'd10; bus.a = 32'h0001_2345; bus.b = 32'h0001_0001; bus.in_valid = 1'b1;
        tick();
        lat  = 1;
        seen = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) seen = 1'b1;
            bus.a = $urandom;
            bus.b = $urandom;
            tick();
            lat++;
        end
        check("mulbusy_in_ready_low", seen, 0);
        check("mulbusy_latency", lat, W + 1);
        check("mulbusy_result", bus.result, 32'h2346_2345);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Back-pressure with a request waiting.
        bus.op = 4'd3; bus.a = 32'd5; bus.b = 32'd7; bus.in_valid = 1'b1;
        tick();
        bus.op = 4'd7; bus.a = 32'd1; bus.b = 32'd2;
        for (int c = 0; c < 10; c++) begin
            check("bp_result",    bus.result, 32'd12);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready",  bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_drop_out_valid", bus.out_valid, 0);
        check("bp_in_ready_back",  bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_held_accepted", bus.out_valid, 1);
        check("bp_held_result",   bus.result, 32'd3);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Random operations against the reference model.
        for (int n = 0; n < 150; n++) begin
            logic [3:0]   op;
            logic [W-1:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (n % 7 == 0) a = 32'h8000_0000 | (a >> 4);
            if (n % 5 == 0) b = b & 32'h1F;
            ref_alu(op, a, b, exp_r, exp_ill, exp_lat);
            run_op(op, a, b, bit'($urandom_range(0, 1)), res, z, s, ill, lat);
            check($sformatf("rnd%0d_op%0d_result", n, op), res, exp_r);
            check($sformatf("rnd%0d_op%0d_flags", n, op), {z, s, ill}, {(exp_r == 0), exp_r[W-1], exp_ill});
            check($sformatf("rnd%0d_op%0d_latency", n, op), lat, exp_lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
